// File: rtl/ext_pkg.sv
// Shared types and constants for the decode-stage operand extension sequencer.
// The SIGN_EXT_EN macro enables sign extension for the opcodes matched by is_signed_imm.
package ext_pkg;

    typedef enum logic [1:0] {
        KIND_NONE  = 2'd0,
        KIND_IMM   = 2'd1,
        KIND_SHAMT = 2'd2,
        KIND_JUMP  = 2'd3
    } op_kind_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    typedef struct packed {
        op_kind_e    kind;
        logic [31:0] operand;
    } entry_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;

    // Arithmetic, branch and load/store opcodes whose immediate is signed.
    function automatic logic is_signed_imm(input logic [5:0] opc);
        return (opc == OP_BEQ)   || (opc == OP_BNE)  || (opc == OP_ADDI) ||
               (opc == OP_ADDIU) || (opc == OP_SLTI) || (opc == OP_SLTIU) ||
               (opc == OP_LW)    || (opc == OP_SW);
    endfunction

endpackage

// File: rtl/ext_classify.sv
// Combinational classifier: decodes an instruction word into its op kind and extended operand.
// SIGN_EXT_EN selects sign extension for signed-immediate opcodes; otherwise all IMMs zero-extend.
module ext_classify
    import ext_pkg::*;
(
    input  logic [31:0] instr,
    output op_kind_e    op_kind,
    output logic [31:0] operand
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    always_comb begin
        op_kind = KIND_IMM;
        operand = {16'b0, instr[15:0]};
        if (opcode == OP_SPECIAL) begin
            if ((funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA)) begin
                op_kind = KIND_SHAMT;
                operand = {27'b0, instr[10:6]};
            end else begin
                op_kind = KIND_NONE;
                operand = 32'b0;
            end
        end else if ((opcode == OP_J) || (opcode == OP_JAL)) begin
            op_kind = KIND_JUMP;
            operand = {6'b0, instr[25:0]};
        end
`ifdef SIGN_EXT_EN
        else if (is_signed_imm(opcode)) begin
            operand = {{16{instr[15]}}, instr[15:0]};
        end
`endif
    end

endmodule

// File: rtl/ext_sequencer.sv
// Operand extension sequencer: classifies at push time and buffers results in a 2-entry skid buffer.
// Sign extension of immediates is controlled by the SIGN_EXT_EN macro (see ext_classify).
module ext_sequencer
    import ext_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] operand,
    output logic [1:0]  op_kind,
    output logic [15:0] issued_count
);

    op_kind_e    new_kind;
    logic [31:0] new_operand;
    entry_t      new_entry;

    skid_state_e state_q, state_d;
    entry_t      head_q, tail_q;
    logic        in_ready_q;
    logic [15:0] count_q;
    logic        push, pop;

    ext_classify u_classify (
        .instr   (instr),
        .op_kind (new_kind),
        .operand (new_operand)
    );

    assign new_entry = '{kind: new_kind, operand: new_operand};

    // in_ready is a register, so pop never reaches it combinationally.
    assign push = in_valid && in_ready_q;
    assign pop  = (state_q != ST_EMPTY) && out_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (push) state_d = ST_ONE;
            ST_ONE: begin
                if (push && !pop)      state_d = ST_FULL;
                else if (pop && !push) state_d = ST_EMPTY;
            end
            ST_FULL:  if (pop) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
        if (flush) state_d = ST_EMPTY;
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            count_q    <= 16'd0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
            if (pop) count_q <= count_q + 16'd1;
            case (state_q)
                ST_EMPTY: if (push) head_q <= new_entry;
                ST_ONE: begin
                    if (push && pop)       head_q <= new_entry;
                    else if (push && !pop) tail_q <= new_entry;
                end
                ST_FULL:  if (pop) head_q <= tail_q;
                default: ;
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = (state_q != ST_EMPTY);
    assign operand      = head_q.operand;
    assign op_kind      = head_q.kind;
    assign issued_count = count_q;

endmodule

// File: tb/tb_ext_sequencer.sv
// Bench for ext_sequencer: queue-based reference model compared every cycle, plus literal checks.
module tb_ext_sequencer;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] instr, operand;
    logic [1:0]  op_kind;
    logic [15:0] issued_count;

    always #5 clock = ~clock;

    ext_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr        (instr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .operand      (operand),
        .op_kind      (op_kind),
        .issued_count (issued_count)
    );

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] operand;
    } ent_t;

    ent_t        model_q[$];
    logic [15:0] exp_count = 16'd0;
    bit          check_en = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          bubbles  = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 50)
                $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference extension rules, written straight from the instruction-set view.
    function automatic void ref_ext(input logic [31:0] w, output logic [1:0] k, output logic [31:0] v);
        logic [5:0] opc;
        logic [5:0] fn;
        opc = w[31:26];
        fn  = w[5:0];
        if (opc == 6'h00) begin
            if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) begin
                k = 2'd2;
                v = 32'(w[10:6]);
            end else begin
                k = 2'd0;
                v = 32'd0;
            end
        end else if (opc == 6'h02 || opc == 6'h03) begin
            k = 2'd3;
            v = 32'(w[25:0]);
        end else begin
            k = 2'd1;
            v = 32'(w[15:0]);
`ifdef SIGN_EXT_EN
            if (opc inside {6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B})
                v = {{16{w[15]}}, w[15:0]};
`endif
        end
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [5:0]  sel_ops [8];
        logic [5:0]  sel_fns [4];
        sel_ops = '{6'h02, 6'h03, 6'h08, 6'h0D, 6'h23, 6'h2B, 6'h0C, 6'h04};
        sel_fns = '{6'h00, 6'h02, 6'h03, 6'h20};
        w = $urandom();
        case ($urandom_range(0, 3))
            0: begin
                w[31:26] = 6'h00;
                w[5:0]   = sel_fns[$urandom_range(0, 3)];
            end
            1, 2: w[31:26] = sel_ops[$urandom_range(0, 7)];
            default: ;
        endcase
        return w;
    endfunction

    // Reference model: a FIFO of at most two classified entries.
    always @(posedge clock) begin : model
        ent_t e;
        int   sz;
        if (reset || flush) begin
            model_q.delete();
            exp_count = 16'd0;
        end else begin
            sz = model_q.size();
            if (sz > 0 && out_ready) begin
                model_q.delete(0);
                exp_count = exp_count + 16'd1;
            end
            if (in_valid && sz < 2) begin
                ref_ext(instr, e.kind, e.operand);
                model_q.push_back(e);
            end
        end
    end

    always @(negedge clock) begin
        if (check_en) begin
            check("out_valid", 32'(out_valid), 32'(model_q.size() > 0));
            check("in_ready", 32'(in_ready), 32'(model_q.size() < 2));
            check("issued_count", 32'(issued_count), 32'(exp_count));
            if (model_q.size() > 0) begin
                check("operand", operand, model_q[0].operand);
                check("op_kind", 32'(op_kind), 32'(model_q[0].kind));
            end
        end
    end

    task automatic push_lit(input string nm, input logic [31:0] w,
                            input logic [31:0] exp_op, input logic [1:0] exp_k);
        instr     = w;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        check({nm, " out_valid"}, 32'(out_valid), 32'd1);
        check({nm, " operand"}, operand, exp_op);
        check({nm, " op_kind"}, 32'(op_kind), 32'(exp_k));
    endtask

    initial begin
        logic [31:0] addi_exp;
`ifdef SIGN_EXT_EN
        addi_exp = 32'hFFFF_FFFC;
`else
        addi_exp = 32'h0000_FFFC;
`endif
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = 32'd0;
        repeat (2) @(negedge clock);
        check_en = 1'b1;
        reset    = 1'b0;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset issued_count", 32'(issued_count), 32'd0);
        check("reset operand", operand, 32'd0);
        check("reset op_kind", 32'(op_kind), 32'd0);

        push_lit("addi", 32'h2008_FFFC, addi_exp, 2'd1);
        push_lit("ori", 32'h3508_FFFC, 32'h0000_FFFC, 2'd1);
        push_lit("sll", 32'h0008_4140, 32'h0000_0005, 2'd2);
        push_lit("j", 32'h0BFF_FFFF, 32'h03FF_FFFF, 2'd3);
        push_lit("add", 32'h0109_5020, 32'h0000_0000, 2'd0);
        @(negedge clock);
        check("drain out_valid", 32'(out_valid), 32'd0);
        check("literal issued_count", 32'(issued_count), 32'd5);

        // Backpressure: two accepted, third waits until the head is popped.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h3508_FFFC;
        @(negedge clock);
        check("bp first in_ready", 32'(in_ready), 32'd1);
        instr = 32'h0008_4140;
        @(negedge clock);
        check("bp full in_ready", 32'(in_ready), 32'd0);
        instr = 32'h0BFF_FFFF;
        repeat (2) begin
            @(negedge clock);
            check("bp hold operand", operand, 32'h0000_FFFC);
            check("bp hold in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clock);
        check("bp second operand", operand, 32'h0000_0005);
        check("bp second op_kind", 32'(op_kind), 32'd2);
        @(negedge clock);
        check("bp third operand", operand, 32'h03FF_FFFF);
        check("bp third op_kind", 32'(op_kind), 32'd3);
        in_valid = 1'b0;
        @(negedge clock);
        check("bp drained", 32'(out_valid), 32'd0);

        // Random traffic with occasional flush.
        for (int i = 0; i < 600; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 49) == 0);
            instr     = rand_instr();
            @(negedge clock);
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        @(negedge clock);
        flush = 1'b0;

        // Streaming: one entry per cycle, counter wraps through 0xFFFF.
        out_ready = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            in_valid = 1'b1;
            instr    = rand_instr();
            @(negedge clock);
            if (!out_valid) bubbles++;
        end
        in_valid = 1'b0;
        @(negedge clock);
        check("stream bubbles", 32'(bubbles), 32'd0);
        check("stream issued_count", 32'(issued_count), 32'd4464);

        // Flush while FULL with push and pop requested.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h2008_0001;
        @(negedge clock);
        instr = 32'h0000_0080;
        @(negedge clock);
        check("flush pre in_ready", 32'(in_ready), 32'd0);
        flush     = 1'b1;
        out_ready = 1'b1;
        instr     = 32'h0BFF_FFFF;
        @(negedge clock);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush out_valid", 32'(out_valid), 32'd0);
        check("flush in_ready", 32'(in_ready), 32'd1);
        check("flush issued_count", 32'(issued_count), 32'd0);
        @(negedge clock);
        check("flush no accept", 32'(out_valid), 32'd0);

        // Reset mid-stream in ONE with push and pop both active.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instr = rand_instr();
            @(negedge clock);
        end
        reset = 1'b1;
        @(negedge clock);
        reset    = 1'b0;
        in_valid = 1'b0;
        check("midreset out_valid", 32'(out_valid), 32'd0);
        check("midreset in_ready", 32'(in_ready), 32'd1);
        check("midreset issued_count", 32'(issued_count), 32'd0);
        check("midreset operand", operand, 32'd0);
        check("midreset op_kind", 32'(op_kind), 32'd0);
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
